mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the 16-entry x 5-bit `memory` block. It gives two independent clients (A and B) shared access to the memory through a req/ack handshake. Round-robin arbitration decides which client is served, and each client can issue one read or write per transaction. A clear sequencer sweeps all 16 locations to zero on command. The block drives `memory`'s `write_enable`, `address` and `data_in` directly and samples its combinational `data_out`.

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-client access sequencer and full-clear sweeper for a 16x5 memory.
// Latency: req sampled in IDLE -> memory driven next cycle -> ack/rdata one cycle later; clear is DEPTH writes then clr_done.
// Backpressure: clients hold req until ack; requests wait out ACCESS/RESP/CLEAR; clr_start outside IDLE is dropped.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 5,
  parameter int DEPTH  = 16
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  input  logic              clr_start,
  output logic              clr_done,
  output logic              busy,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  // Last address of the sweep; the counter wraps back to 0 after it.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t            state;
  logic              last_grant;
  logic              cmd_sel;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0] clr_cnt;

  logic              any_req;
  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Arbitration: a lone requester wins; on a tie the client that did not win last time goes.
  always_comb begin
    any_req   = req_a | req_b;
    pick_b    = req_b & (~req_a | (last_grant == GRANT_A));
    sel_we    = pick_b ? we_b    : we_a;
    sel_addr  = pick_b ? addr_b  : addr_a;
    sel_wdata = pick_b ? wdata_b : wdata_a;
  end

  assign busy = (state != IDLE);

  // Sequencer: owns the state, command registers, clear counter and every registered output.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      last_grant       <= GRANT_B;
      cmd_sel          <= GRANT_A;
      cmd_we           <= 1'b0;
      cmd_addr         <= '0;
      cmd_wdata        <= '0;
      clr_cnt          <= '0;
      ack_a            <= 1'b0;
      ack_b            <= 1'b0;
      rdata            <= '0;
      clr_done         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
    end else begin
      // Pulses last exactly one cycle unless a state below re-asserts them.
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      clr_done <= 1'b0;

      case (state)
        IDLE: begin
          if (clr_start) begin
            // Clear beats any pending request; the request is served after the sweep.
            state            <= CLEAR;
            clr_cnt          <= '0;
            mem_write_enable <= 1'b1;
            mem_address      <= '0;
            mem_data_in      <= '0;
          end else if (any_req) begin
            state            <= ACCESS;
            cmd_sel          <= pick_b;
            cmd_we           <= sel_we;
            cmd_addr         <= sel_addr;
            cmd_wdata        <= sel_wdata;
            last_grant       <= pick_b;
            // Outputs are registered, so the memory sees the command during ACCESS.
            mem_write_enable <= sel_we;
            mem_address      <= sel_addr;
            mem_data_in      <= sel_we ? sel_wdata : '0;
          end
        end

        ACCESS: begin
          // Reads capture the memory's combinational output; writes echo the written data.
          rdata            <= cmd_we ? cmd_wdata : mem_data_out;
          ack_a            <= (cmd_sel == GRANT_A);
          ack_b            <= (cmd_sel == GRANT_B);
          mem_write_enable <= 1'b0;
          mem_address      <= '0;
          mem_data_in      <= '0;
          state            <= RESP;
        end

        RESP: begin
          state <= IDLE;
        end

        CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state            <= IDLE;
            clr_done         <= 1'b1;
            clr_cnt          <= '0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_data_in      <= '0;
          end else begin
            clr_cnt          <= clr_cnt + 1'b1;
            mem_write_enable <= 1'b1;
            mem_address      <= clr_cnt + 1'b1;
            mem_data_in      <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Only one client is ever acknowledged at a time.
  a_ack_exclusive: assert property (@(posedge Clk) disable iff (!reset_n)
    !(ack_a && ack_b));

  // Acks only appear in the response cycle.
  a_ack_in_resp: assert property (@(posedge Clk) disable iff (!reset_n)
    (ack_a || ack_b) |-> (state == RESP));

  // The memory is written only by a write command or by the sweep.
  a_we_scope: assert property (@(posedge Clk) disable iff (!reset_n)
    mem_write_enable |-> (((state == ACCESS) && cmd_we) || (state == CLEAR)));

  // During ACCESS the memory address is the latched command address.
  a_access_addr: assert property (@(posedge Clk) disable iff (!reset_n)
    (state == ACCESS) |-> (mem_address == cmd_addr));

  // During the sweep the address tracks the counter and the data is zero.
  a_clear_addr: assert property (@(posedge Clk) disable iff (!reset_n)
    (state == CLEAR) |-> ((mem_address == clr_cnt) && (mem_data_in == '0) && mem_write_enable));

  // The memory port is quiet in IDLE and RESP.
  a_quiet: assert property (@(posedge Clk) disable iff (!reset_n)
    ((state == IDLE) || (state == RESP)) |-> (!mem_write_enable && (mem_address == '0) && (mem_data_in == '0)));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural 16x5 memory attached.
// Stimulus pushes expected acks, memory writes and clr_done cycles; a negedge monitor pops and compares.
// Clients hold req until ack and present the next command right after the ack cycle.
module tb_mem_arbiter;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       we_a = 1'b0, we_b = 1'b0;
  logic [3:0] addr_a = '0, addr_b = '0;
  logic [4:0] wdata_a = '0, wdata_b = '0;
  logic       ack_a, ack_b;
  logic [4:0] rdata;
  logic       clr_start = 1'b0;
  logic       clr_done;
  logic       busy;
  logic       mem_write_enable;
  logic [3:0] mem_address;
  logic [4:0] mem_data_in;
  logic [4:0] mem_data_out;

  mem_arbiter #(.ADDR_W(4), .DATA_W(5), .DEPTH(16)) dut (
    .Clk(Clk), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata),
    .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 Clk = ~Clk;

  // Behavioural memory: synchronous write, combinational read.
  logic [4:0] mem_model [16];
  always @(posedge Clk) if (mem_write_enable) mem_model[mem_address] <= mem_data_in;
  assign mem_data_out = mem_model[mem_address];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] rdata; } ack_exp_t;
  typedef struct { int cyc; logic [3:0] addr; logic [4:0] data; } wr_exp_t;

  ack_exp_t exp_a[$];
  ack_exp_t exp_b[$];
  wr_exp_t  exp_wr[$];
  int       exp_done[$];
  int       ack_log[$];

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every DUT event against what the stimulus predicted.
  ack_exp_t mon_e;
  int       mon_idx;
  always @(negedge Clk) begin
    if (reset_n) begin
      if (ack_a) begin
        ack_log.push_back(0);
        chk("ack_a_pending", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          mon_e = exp_a.pop_front();
          chk("ack_a_cycle", cyc, mon_e.cyc);
          chk("ack_a_rdata", 32'(rdata), 32'(mon_e.rdata));
        end
        chk("busy_in_resp_a", 32'(busy), 32'd1);
      end
      if (ack_b) begin
        ack_log.push_back(1);
        chk("ack_b_pending", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          mon_e = exp_b.pop_front();
          chk("ack_b_cycle", cyc, mon_e.cyc);
          chk("ack_b_rdata", 32'(rdata), 32'(mon_e.rdata));
        end
        chk("busy_in_resp_b", 32'(busy), 32'd1);
      end
      if (mem_write_enable) begin
        mon_idx = -1;
        foreach (exp_wr[i]) if (exp_wr[i].cyc == cyc) mon_idx = i;
        chk("mem_write_expected", 32'(mon_idx >= 0), 32'd1);
        if (mon_idx >= 0) begin
          chk("mem_write_addr", 32'(mem_address), 32'(exp_wr[mon_idx].addr));
          chk("mem_write_data", 32'(mem_data_in), 32'(exp_wr[mon_idx].data));
          exp_wr.delete(mon_idx);
        end
      end
      if (clr_done) begin
        chk("clr_done_pending", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) chk("clr_done_cycle", cyc, exp_done.pop_front());
        chk("busy_at_clr_done", 32'(busy), 32'd0);
      end
    end
  end

  // One client transaction; returns one cycle after the ack with req still high.
  task automatic client_txn(input bit is_b, input bit we, input logic [3:0] addr,
                            input logic [4:0] wdata, input logic [4:0] exp_rdata, input int exp_cyc);
    ack_exp_t e;
    wr_exp_t  w;
    bit       seen;
    e.cyc   = exp_cyc;
    e.rdata = we ? wdata : exp_rdata;
    if (we) begin
      w.cyc  = exp_cyc - 1;
      w.addr = addr;
      w.data = wdata;
      exp_wr.push_back(w);
    end
    if (is_b) begin
      exp_b.push_back(e);
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
    end else begin
      exp_a.push_back(e);
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
    end
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge Clk);
      seen = is_b ? ack_b : ack_a;
    end
    chk(is_b ? "ack_b_arrived" : "ack_a_arrived", 32'(seen), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  // One-cycle clr_start pulse with the full sweep and clr_done predicted.
  task automatic do_clear();
    wr_exp_t w;
    for (int i = 0; i < 16; i++) begin
      w.cyc  = cyc + 1 + i;
      w.addr = 4'(i);
      w.data = 5'd0;
      exp_wr.push_back(w);
    end
    exp_done.push_back(cyc + 17);
    clr_start = 1'b1;
    @(posedge Clk);
    #1;
    clr_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack_a"}, 32'(ack_a), 32'd0);
    chk({tag, "_ack_b"}, 32'(ack_b), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_clr_done"}, 32'(clr_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_write_enable), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_address), 32'd0);
    chk({tag, "_mem_din"}, 32'(mem_data_in), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state.
    reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // A writes 0x15 @3 then reads it back; ack two cycles after each request.
    client_txn(1'b0, 1'b1, 4'd3, 5'h15, 5'h00, cyc + 2);
    client_txn(1'b0, 1'b0, 4'd3, 5'h00, 5'h15, cyc + 2);
    req_a = 1'b0;

    // Tie straight out of reset: A first, B three cycles later.
    reset_n = 1'b0;
    @(posedge Clk);
    #1;
    reset_n = 1'b1;
    fork
      begin client_txn(1'b0, 1'b1, 4'd5, 5'h0A, 5'h00, cyc + 2); req_a = 1'b0; end
      begin client_txn(1'b1, 1'b1, 4'd9, 5'h11, 5'h00, cyc + 5); req_b = 1'b0; end
    join
    client_txn(1'b0, 1'b0, 4'd5, 5'h00, 5'h0A, cyc + 2);
    req_a = 1'b0;
    client_txn(1'b1, 1'b0, 4'd9, 5'h00, 5'h11, cyc + 2);
    req_b = 1'b0;

    // Both clients request continuously: acks alternate A, B, A, B, A, B.
    ack_log.delete();
    begin
      int s;
      s = cyc;
      fork
        begin
          client_txn(1'b0, 1'b1, 4'd0, 5'h01, 5'h00, s + 2);
          client_txn(1'b0, 1'b1, 4'd1, 5'h02, 5'h00, s + 8);
          client_txn(1'b0, 1'b0, 4'd0, 5'h00, 5'h01, s + 14);
          req_a = 1'b0;
        end
        begin
          client_txn(1'b1, 1'b1, 4'd15, 5'h1F, 5'h00, s + 5);
          client_txn(1'b1, 1'b0, 4'd15, 5'h00, 5'h1F, s + 11);
          client_txn(1'b1, 1'b0, 4'd5, 5'h00, 5'h0A, s + 17);
          req_b = 1'b0;
        end
      join
    end
    chk("alt_count", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("alt_order", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));

    // Fill with nonzero data, then clear with a simultaneous B request.
    for (int i = 0; i < 16; i++)
      client_txn(1'b0, 1'b1, 4'(i), 5'(i + 1), 5'h00, cyc + 2);
    req_a = 1'b0;
    fork
      do_clear();
      begin client_txn(1'b1, 1'b0, 4'd7, 5'h00, 5'h00, cyc + 19); req_b = 1'b0; end
    join
    for (int i = 0; i < 16; i++)
      client_txn(1'b0, 1'b0, 4'(i), 5'h00, 5'h00, cyc + 2);
    req_a = 1'b0;

    // Reset during cycle 8 of a clear: outputs drop at once, no clr_done, sweep restarts at 0.
    do_clear();
    repeat (7) @(posedge Clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midclear");
    chk("writes_left_at_reset", 32'(exp_wr.size()), 32'd9);
    chk("done_left_at_reset", 32'(exp_done.size()), 32'd1);
    exp_wr.delete();
    exp_done.delete();
    @(posedge Clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    do_clear();
    client_txn(1'b0, 1'b0, 4'd3, 5'h00, 5'h00, cyc + 18);
    client_txn(1'b0, 1'b0, 4'd12, 5'h00, 5'h00, cyc + 2);
    req_a = 1'b0;

    repeat (3) @(posedge Clk);
    #1;
    chk("exp_a_left", 32'(exp_a.size()), 32'd0);
    chk("exp_b_left", 32'(exp_b.size()), 32'd0);
    chk("exp_wr_left", 32'(exp_wr.size()), 32'd0);
    chk("exp_done_left", 32'(exp_done.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
